// File: rtl/logic_gate_pkg.sv
// Shared encodings and payload types for the registered bitwise logic unit.
package logic_gate_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_NOR   = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

    // Status flags travelling alongside the registered result.
    typedef struct packed {
        logic zero;
        logic parity;
    } flags_t;

endpackage

// File: rtl/logic_gate_core.sv
// Purely combinational gate selector: (op, a, b) -> result_c.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_c
);

    always_comb begin
        result_c = '0;
        unique case (op)
            OP_AND:   result_c = a & b;
            OP_OR:    result_c = a | b;
            OP_NOR:   result_c = ~(a | b);
            OP_XOR:   result_c = a ^ b;
            OP_NAND:  result_c = ~(a & b);
            OP_XNOR:  result_c = ~(a ^ b);
            OP_NOTA:  result_c = ~a;
            OP_PASSB: result_c = b;
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit with valid/ready handshake and accumulator chaining.
// Optional popcount output enabled by defining LOGIC_GATE_POPCNT_EN.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_GATE_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a_c;
    logic [WIDTH-1:0] result_c;
    logic             accept_c;
    flags_t           flags_q;

    // Output register drains or is empty: a new operand set can be taken.
    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // A clear arriving with an accumulate op sees a zero accumulator.
    assign op_a_c = acc_mode ? (acc_clr ? '0 : acc) : a;

    logic_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op       (op),
        .a        (op_a_c),
        .b        (b),
        .result_c (result_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            flags_q   <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else if (accept_c) begin
            y              <= result_c;
            flags_q.zero   <= (result_c == '0);
            flags_q.parity <= ^result_c;
            out_valid      <= 1'b1;
            acc            <= result_c;
            op_count       <= op_count + CNT_W'(1);
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc_clr) begin
                acc <= '0;
            end
        end
    end

    assign zero   = flags_q.zero;
    assign parity = flags_q.parity;

`ifdef LOGIC_GATE_POPCNT_EN
    localparam int unsigned PC_W = $clog2(WIDTH + 1);

    logic [PC_W-1:0] pc_c;

    always_comb begin
        pc_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc_c = pc_c + PC_W'(result_c[i]);
        end
    end

    // Popcount shares the result register's load/hold behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popcnt <= '0;
        end else if (accept_c) begin
            popcnt <= pc_c;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed + randomized scoreboard bench for logic_gate_unit (WIDTH=8, CNT_W=4).
module tb_logic_gate_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] op_count;
`ifdef LOGIC_GATE_POPCNT_EN
    logic [3:0]       popcnt;
`endif

    always #5 clk = ~clk;

    logic_gate_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity),
        .op_count  (op_count)
`ifdef LOGIC_GATE_POPCNT_EN
        ,
        .popcnt    (popcnt)
`endif
    );

    logic [WIDTH-1:0] sbq[$];
    logic [WIDTH-1:0] obs[$];
    logic [WIDTH-1:0] m_acc;
    logic [CNT_W-1:0] m_cnt;
    int               n_chk = 0;
    int               n_fail = 0;

    function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return ~(x | z);
            3'd3:    return x ^ z;
            3'd4:    return ~(x & z);
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return z;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: scoreboard pop/push at negedge, then advance past the rising edge.
    task automatic step();
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] ey;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL sb_underflow observed=%0h expected=none", y);
            end else begin
                ey = sbq.pop_front();
                obs.push_back(y);
                chk("y", 32'(y), 32'(ey));
                chk("zero", 32'(zero), 32'(ey == '0));
                chk("parity", 32'(parity), 32'(^ey));
`ifdef LOGIC_GATE_POPCNT_EN
                chk("popcnt", 32'(popcnt), 32'($countones(ey)));
`endif
            end
        end
        chk("op_count", 32'(op_count), 32'(m_cnt));
        if (in_valid && in_ready) begin
            ea = acc_mode ? (acc_clr ? '0 : m_acc) : a;
            ey = ref_gate(op, ea, b);
            sbq.push_back(ey);
            m_acc = ey;
            m_cnt = m_cnt + 1'b1;
        end else if (acc_clr) begin
            m_acc = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sbq.delete();
        m_acc = '0;
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
    endtask

    logic [WIDTH-1:0] tbl_y[8];
    logic [WIDTH-1:0] acc_y[4];
    logic [CNT_W-1:0] cnt0;

    initial begin
        tbl_y = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h3A, 8'h3A};
        acc_y = '{8'h01, 8'h03, 8'h07, 8'h0F};
        rst_n = 1'b0; in_valid = 1'b0; op = '0; acc_mode = 1'b0; acc_clr = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        m_acc = '0; m_cnt = '0;
        #12;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_zero", 32'(zero), 32'h0);
        chk("rst_parity", 32'(parity), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Each op on C5/3A, back to back.
        obs.delete();
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 8'hC5, 8'h3A);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("tbl_count", 32'(obs.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs.size(); i++) chk("tbl_y", 32'(obs[i]), 32'(tbl_y[i]));

        // Random traffic including back-pressure, accumulate and clears.
        for (int i = 0; i < 40; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            acc_mode  = 1'($urandom_range(0, 1));
            acc_clr   = ($urandom_range(0, 7) == 0);
            op        = 3'($urandom);
            a         = 8'($urandom);
            b         = 8'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; acc_mode = 1'b0; acc_clr = 1'b0;
        step(); step();

        // Back-pressure: result held three cycles, no accept while stalled.
        drive(3'd0, 8'hFF, 8'h55);
        step();
        out_ready = 1'b0;
        drive(3'd3, 8'h12, 8'h34);
        cnt0 = op_count;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_y", 32'(y), 32'h55);
            chk("stall_out_valid", 32'(out_valid), 32'h1);
            chk("stall_op_count", 32'(op_count), 32'(cnt0));
        end
        out_ready = 1'b1;
        drive(3'd1, 8'h0F, 8'hF0);
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);
        step();
        chk("release_op_count", 32'(op_count), 32'(CNT_W'(cnt0 + 1'b1)));
        chk("release_y", 32'(y), 32'hFF);
        in_valid = 1'b0;
        step(); step();

        // Accumulate OR chain.
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        acc_mode = 1'b1;
        obs.delete();
        cnt0 = op_count;
        for (int i = 0; i < 4; i++) begin
            drive(3'd1, 8'h00, 8'(1 << i));
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("acc_count", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("acc_y", 32'(obs[i]), 32'(acc_y[i]));
        chk("acc_op_count", 32'(CNT_W'(op_count - cnt0)), 32'd4);

        // Clear coinciding with accept: A=0, accumulator takes the result.
        obs.delete();
        acc_mode = 1'b0;
        drive(3'd7, 8'h00, 8'hF0);
        step();
        acc_mode = 1'b1; acc_clr = 1'b1;
        drive(3'd3, 8'h00, 8'h0F);
        step();
        acc_clr = 1'b0;
        drive(3'd1, 8'h00, 8'h00);
        step();
        in_valid = 1'b0;
        step(); step();
        chk("clracc_count", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) begin
            chk("clracc_y", 32'(obs[1]), 32'h0F);
            chk("clracc_acc", 32'(obs[2]), 32'h0F);
        end

        // Asynchronous reset during a stall.
        acc_mode = 1'b0;
        drive(3'd7, 8'h00, 8'hA5);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_y", 32'(y), 32'h0);
        chk("arst_op_count", 32'(op_count), 32'h0);
        out_ready = 1'b1;
        sbq.delete(); m_acc = '0; m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        obs.delete();
        acc_mode = 1'b1;
        drive(3'd1, 8'hFF, 8'h00);
        step();
        in_valid = 1'b0; acc_mode = 1'b0;
        step();
        chk("arst_acc", 32'(obs.size() > 0 ? obs[0] : 8'hXX), 32'h00);

        // Counter wraps at 2^CNT_W.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(3'($urandom), 8'($urandom), 8'($urandom));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_op_count", 32'(op_count), 32'h1);

`ifdef LOGIC_GATE_POPCNT_EN
        drive(3'd0, 8'hFF, 8'h0F);
        step();
        in_valid = 1'b0;
        step();
        chk("popcnt_and", 32'(popcnt), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
